mac_tap_sequencer: RTL
======================

// Module: mac_tap_sequencer
// PURPOSE
//  Sequences MultiMultiplier8x8 over a multi-tap convolution window: accepts data/weight pairs over a valid/ready stream
//  and registers them onto the multiplier inputs. Accumulates addL_res_o/addM_res_o over cfg_taps products and
//  returns the sums over a valid/ready result port. Sits between the line/weight buffers and the conv output stage.
// PARAMETERS
//  ACC_W   24  accumulator width (signed), >= 19
//  CNT_W   5   tap counter width; max taps = 2**CNT_W-1
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      reset, synchronous, active-low
//  cfg_start      in   1      start a window (sampled in IDLE only)
//  cfg_abort      in   1      abandon current window
//  cfg_taps       in   CNT_W  number of products to accumulate
//  cfg_convtypeD  in   2      data conv type (01 CONV_2, 10 CONV_4, 11 CONV_8)
//  cfg_convtypeW  in   2      weight conv type (same encoding)
//  s_valid        in   1      operand valid
//  s_ready        out  1      operand accepted when s_valid&s_ready
//  s_d            in   8      unsigned data
//  s_w            in   32     signed weights {w4,w3,w2,w1}
//  mul_d          out  8      to multiplier d
//  mul_w1..mul_w4 out  8 each to multiplier w1..w4
//  mul_convtypeD  out  2      to multiplier convtypeD
//  mul_convtypeW  out  2      to multiplier convtypeW
//  mul_resL       in   19     from multiplier addL_res_o (signed)
//  mul_resM       in   15     from multiplier addM_res_o (signed)
//  m_valid        out  1      result valid
//  m_ready        in   1      result consumed when m_valid&m_ready
//  m_accL         out  ACC_W  accumulated L sum
//  m_accM         out  ACC_W  accumulated M sum
//  m_sat          out  1      either sum saturated during window
//  busy           out  1      state != IDLE
//  cfg_err        out  1      one-cycle pulse: start rejected
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE; every output 0, incl. mul_* operands, accumulators and counters.
//  States: IDLE -> RUN -> DRAIN -> OUT -> IDLE.
//  IDLE: on cfg_start, if cfg_taps==0 or either convtype==2'b00, pulse cfg_err and stay IDLE.
//    Otherwise latch taps and convtypes (held on mul_convtype* for the whole window), clear acc/sat/counters, go RUN.
//  RUN: s_ready = (issued < taps). On a handshake, register s_d/s_w onto mul_* and set p_vld=1.
//    Otherwise p_vld=0; mul_* hold their values. Throughput is 1 pair/cycle.
//  Multiplier is combinational; on the cycle after issue (p_vld=1), sign-extend mul_resL/mul_resM to ACC_W and add.
//    Then accumulated++.
//  Issue and accumulate of consecutive taps overlap every cycle.
//  On the last issue, go DRAIN. In DRAIN, s_ready=0; when accumulated==taps, go OUT. Issue-to-OUT latency is 2 cycles.
//  OUT: m_valid=1; m_accL/m_accM stable until m_ready. On the handshake go IDLE next cycle; m_valid drops.
//  m_ready low in OUT: hold indefinitely; s_ready stays 0.
//  Saturation: a sum exceeding +/-(2**(ACC_W-1)) clamps to the bound and sets m_sat (sticky for the window).
//  cfg_start outside IDLE: ignored, no cfg_err.
//  cfg_abort in RUN/DRAIN/OUT: IDLE next cycle; acc, counters and p_vld cleared; m_valid never asserted for the window.
//    The pipelined product is discarded. cfg_abort has priority over s/m handshakes in the same cycle.
//  cfg_abort in IDLE: no effect; it has priority over a same-cycle cfg_start.
//  Reset mid-window: identical to power-on reset; no partial result is emitted.
//  s_valid with s_ready=0: pair not consumed; the source must hold it.
// STRUCTURE
//  Shared package conv_pkg: CONV_2/CONV_4/CONV_8 encodings, state encoding, ACC_W default.
//  One sub-module, sat_acc: signed saturating accumulator (clear, en, in[18:0] sign-extended, sat flag).
//    Instantiated twice (L and M sums).
//  The FSM, counters and operand registers live in the top module. No multiplier inside; it is connected externally.
// TESTING
//  Bench instantiates MultiMultiplier8x8 wired to mul_*; reference model is sum(d*w1) per window.
//  1) CONV_8/CONV_8, taps=4, s_d=8'hFF, w1=8'h7F, s_valid tied 1 -> m_accL=129540, m_valid 2 cycles after last issue.
//  2) taps=3, s_valid toggling 1,0,1,0,1, m_ready held 0 for 5 cycles -> correct sum; m_accL stable while stalled.
//  3) ACC_W=19, taps=31, d=FF, w1=7F -> m_accL=2**18-1, m_sat=1.
//  4) cfg_taps=0 or convtypeD=00 with cfg_start -> cfg_err one cycle, busy stays 0.
//  5) cfg_abort after 2 of 4 taps, then a new window taps=1, d=2, w1=-3 -> only m_accL=-6 emitted.
//  6) rst=0 for 1 cycle mid-RUN -> all outputs 0 next cycle, state IDLE, no m_valid.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared encodings for the MAC tap sequencer: conv-type codes, FSM states
// and the multiplier result widths.
package conv_pkg;

   typedef enum logic [1:0] {
      CONV_NONE = 2'b00,
      CONV_2    = 2'b01,
      CONV_4    = 2'b10,
      CONV_8    = 2'b11
   } conv_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   localparam int ACC_W_DEF = 24;
   localparam int RES_L_W   = 19;
   localparam int RES_M_W   = 15;

   function automatic logic conv_ok(input logic [1:0] ct);
      return ct != CONV_NONE;
   endfunction

endpackage

// File: rtl/sat_acc.sv
// Signed saturating accumulator: sign-extends a 19-bit product term and adds it,
// clamping at the ACC_W two's-complement bounds with a sticky saturation flag.
module sat_acc
   import conv_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       en_i,
   input  logic signed [RES_L_W-1:0]  in_i,
   output logic signed [ACC_W-1:0]    acc_o,
   output logic                       sat_o
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    sat_q, sat_d;
   logic signed [ACC_W:0]   sum_w;

   function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] s);
      if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
      return s[ACC_W-1:0];
   endfunction

   function automatic logic overflowed(input logic signed [ACC_W:0] s);
      return s[ACC_W] != s[ACC_W-1];
   endfunction

   // one guard bit above ACC_W exposes overflow of a single add
   assign sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-RES_L_W){in_i[RES_L_W-1]}}, in_i};

   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      if (clr_i) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (en_i) begin
         acc_d = clamp(sum_w);
         sat_d = sat_q | overflowed(sum_w);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc_o = acc_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/mac_tap_sequencer.sv
// Feeds data/weight pairs to an external 8x8 multiplier and accumulates its
// L/M results over a configured number of taps, returning both sums on a result port.
module mac_tap_sequencer
   import conv_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_start,
   input  logic                      cfg_abort,
   input  logic [CNT_W-1:0]          cfg_taps,
   input  logic [1:0]                cfg_convtypeD,
   input  logic [1:0]                cfg_convtypeW,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [7:0]                s_d,
   input  logic [31:0]               s_w,
   output logic [7:0]                mul_d,
   output logic [7:0]                mul_w1,
   output logic [7:0]                mul_w2,
   output logic [7:0]                mul_w3,
   output logic [7:0]                mul_w4,
   output logic [1:0]                mul_convtypeD,
   output logic [1:0]                mul_convtypeW,
   input  logic signed [RES_L_W-1:0] mul_resL,
   input  logic signed [RES_M_W-1:0] mul_resM,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic signed [ACC_W-1:0]   m_accL,
   output logic signed [ACC_W-1:0]   m_accM,
   output logic                      m_sat,
   output logic                      busy,
   output logic                      cfg_err
);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         taps_q, taps_d;
   logic [CNT_W-1:0]         issued_q, issued_d;
   logic [CNT_W-1:0]         accd_q, accd_d;
   logic [1:0]               ctd_q, ctd_d, ctw_q, ctw_d;
   logic [7:0]               opd_q, opd_d;
   logic [31:0]              opw_q, opw_d;
   logic                     vld_p1_q, vld_p1_d;
   logic                     err_q, err_d;
   logic                     acc_clr, acc_en, s_hs;
   logic                     sat_l, sat_m;
   logic signed [RES_L_W-1:0] res_m_ext;

   assign s_ready   = (state_q == ST_RUN) && (issued_q < taps_q);
   assign s_hs      = s_valid && s_ready;
   assign res_m_ext = {{(RES_L_W-RES_M_W){mul_resM[RES_M_W-1]}}, mul_resM};

   always_comb begin
      state_d  = state_q;
      taps_d   = taps_q;
      ctd_d    = ctd_q;
      ctw_d    = ctw_q;
      issued_d = issued_q;
      accd_d   = accd_q;
      opd_d    = opd_q;
      opw_d    = opw_q;
      vld_p1_d = 1'b0;
      err_d    = 1'b0;
      acc_clr  = 1'b0;
      acc_en   = vld_p1_q;
      if (vld_p1_q) accd_d = accd_q + CNT_W'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start && !cfg_abort) begin
               if (cfg_taps == '0 || !conv_ok(cfg_convtypeD) || !conv_ok(cfg_convtypeW)) begin
                  err_d = 1'b1;
               end else begin
                  taps_d   = cfg_taps;
                  ctd_d    = cfg_convtypeD;
                  ctw_d    = cfg_convtypeW;
                  issued_d = '0;
                  accd_d   = '0;
                  acc_clr  = 1'b1;
                  state_d  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (s_hs) begin
               opd_d    = s_d;
               opw_d    = s_w;
               vld_p1_d = 1'b1;
               issued_d = issued_q + CNT_W'(1);
               if (issued_d == taps_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (accd_q == taps_q) state_d = ST_OUT;
         end
         ST_OUT: begin
            if (m_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // abort discards the in-flight product and any same-cycle handshake
      if (cfg_abort && state_q != ST_IDLE) begin
         state_d  = ST_IDLE;
         issued_d = '0;
         accd_d   = '0;
         opd_d    = opd_q;
         opw_d    = opw_q;
         vld_p1_d = 1'b0;
         acc_clr  = 1'b1;
         acc_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         taps_q   <= '0;
         ctd_q    <= '0;
         ctw_q    <= '0;
         issued_q <= '0;
         accd_q   <= '0;
         opd_q    <= '0;
         opw_q    <= '0;
         vld_p1_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         taps_q   <= taps_d;
         ctd_q    <= ctd_d;
         ctw_q    <= ctw_d;
         issued_q <= issued_d;
         accd_q   <= accd_d;
         opd_q    <= opd_d;
         opw_q    <= opw_d;
         vld_p1_q <= vld_p1_d;
         err_q    <= err_d;
      end
   end

   sat_acc #(.ACC_W(ACC_W)) u_acc_l (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .in_i  (mul_resL),
      .acc_o (m_accL),
      .sat_o (sat_l)
   );

   sat_acc #(.ACC_W(ACC_W)) u_acc_m (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .in_i  (res_m_ext),
      .acc_o (m_accM),
      .sat_o (sat_m)
   );

   assign mul_d         = opd_q;
   assign mul_w1        = opw_q[7:0];
   assign mul_w2        = opw_q[15:8];
   assign mul_w3        = opw_q[23:16];
   assign mul_w4        = opw_q[31:24];
   assign mul_convtypeD = ctd_q;
   assign mul_convtypeW = ctw_q;
   assign m_valid       = (state_q == ST_OUT);
   assign m_sat         = sat_l | sat_m;
   assign busy          = (state_q != ST_IDLE);
   assign cfg_err       = err_q;

endmodule
